// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: counter encodings and defaults.
package bp_pkg;

    typedef enum logic [1:0] {
        CtrStrongNt = 2'b00,
        CtrWeakNt   = 2'b01,
        CtrWeakT    = 2'b10,
        CtrStrongT  = 2'b11
    } ctr_e;

    localparam logic [1:0]  CtrReset      = CtrWeakNt;
    localparam logic [1:0]  CtrAlloc      = CtrWeakT;
    localparam logic [15:0] CntMaxDefault = 16'hFFFF;

endpackage

// File: rtl/bp_sat_ctr.sv
// Two-bit saturating direction counter with a load path for entry allocation.
module bp_sat_ctr
    import bp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       inc_i,
    input  logic       dec_i,
    input  logic       load_i,
    input  logic [1:0] load_val_i,
    output logic [1:0] state_o
);

    logic [1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = load_val_i;
        end else if (en_i) begin
            if (inc_i && state_q != CtrStrongT) begin
                state_d = state_q + 2'd1;
            end else if (dec_i && state_q != CtrStrongNt) begin
                state_d = state_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CtrReset;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters and a saturating mispredict counter.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned PC_W    = 32,
    parameter logic [15:0] CNT_MAX = CntMaxDefault
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] pc_i,
    output logic            pred_taken_o,
    output logic [PC_W-1:0] pred_target_o,
    input  logic            upd_valid_i,
    input  logic [PC_W-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [PC_W-1:0] upd_target_i,
    input  logic            upd_mispred_i,
    input  logic            clr_i,
    output logic [15:0]     mispred_cnt_o
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = PC_W - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [TAG_W-1:0]   tag_d [ENTRIES];
    logic [PC_W-1:0]    tgt_q [ENTRIES];
    logic [PC_W-1:0]    tgt_d [ENTRIES];
    logic [1:0]         ctr   [ENTRIES];
    logic [ENTRIES-1:0] ctr_en, ctr_load;
    logic [15:0]        cnt_q, cnt_d;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit;
    logic             unused_pc_lsbs;

    assign lk_idx = pc_i[IDX_W+1:2];
    assign lk_tag = pc_i[PC_W-1:IDX_W+2];
    assign up_idx = upd_pc_i[IDX_W+1:2];
    assign up_tag = upd_pc_i[PC_W-1:IDX_W+2];
    assign unused_pc_lsbs = ^{pc_i[1:0], upd_pc_i[1:0]};

    // Lookup reads only registered state, so a same-cycle update is not visible.
    assign lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign up_hit        = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign pred_taken_o  = lk_hit && ctr[lk_idx][1];
    assign pred_target_o = pred_taken_o ? tgt_q[lk_idx] : pc_i + PC_W'(4);

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        tgt_d    = tgt_q;
        ctr_en   = '0;
        ctr_load = '0;
        if (clr_i) begin
            valid_d = '0;
        end else if (upd_valid_i) begin
            if (up_hit) begin
                ctr_en[up_idx] = 1'b1;
                if (upd_taken_i) begin
                    tgt_d[up_idx] = upd_target_i;
                end
            end else if (upd_taken_i) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                tgt_d[up_idx]    = upd_target_i;
                ctr_load[up_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (upd_valid_i && upd_mispred_i && (cnt_q < CNT_MAX)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
        end
    end

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
        bp_sat_ctr u_ctr (
            .clk        (clk),
            .rst        (rst),
            .en_i       (ctr_en[g]),
            .inc_i      (upd_taken_i),
            .dec_i      (!upd_taken_i),
            .load_i     (ctr_load[g]),
            .load_val_i (CtrAlloc),
            .state_o    (ctr[g])
        );
    end

    assign mispred_cnt_o = cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: default instance plus one with CNT_MAX=3.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic        upd_mispred_i;
    logic        clr_i;

    logic        pred_taken_o, pred_taken3_o;
    logic [31:0] pred_target_o, pred_target3_o;
    logic [15:0] mispred_cnt_o, mispred_cnt3_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk           (clk),
        .rst           (rst),
        .pc_i          (pc_i),
        .pred_taken_o  (pred_taken_o),
        .pred_target_o (pred_target_o),
        .upd_valid_i   (upd_valid_i),
        .upd_pc_i      (upd_pc_i),
        .upd_taken_i   (upd_taken_i),
        .upd_target_i  (upd_target_i),
        .upd_mispred_i (upd_mispred_i),
        .clr_i         (clr_i),
        .mispred_cnt_o (mispred_cnt_o)
    );

    branch_predictor #(.CNT_MAX(16'd3)) dut3 (
        .clk           (clk),
        .rst           (rst),
        .pc_i          (pc_i),
        .pred_taken_o  (pred_taken3_o),
        .pred_target_o (pred_target3_o),
        .upd_valid_i   (upd_valid_i),
        .upd_pc_i      (upd_pc_i),
        .upd_taken_i   (upd_taken_i),
        .upd_target_i  (upd_target_i),
        .upd_mispred_i (upd_mispred_i),
        .clr_i         (clr_i),
        .mispred_cnt_o (mispred_cnt3_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic lookup(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                          input string tag);
        pc_i = pc;
        #1;
        check({tag, ".taken"}, {31'd0, pred_taken_o}, {31'd0, taken});
        check({tag, ".target"}, pred_target_o, tgt);
    endtask

    // Drive one update for a single clock edge, then drop upd_valid_i.
    task automatic update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                          input logic mis);
        upd_valid_i   = 1'b1;
        upd_pc_i      = pc;
        upd_taken_i   = taken;
        upd_target_i  = tgt;
        upd_mispred_i = mis;
        @(posedge clk);
        #1;
        upd_valid_i   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        logic exp_t [6];
        logic [15:0] exp_c3 [5];
        exp_t  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_c3 = '{16'd1, 16'd2, 16'd3, 16'd3, 16'd3};

        rst = 1'b0; pc_i = 32'h40; upd_valid_i = 1'b0; upd_pc_i = '0; upd_taken_i = 1'b0;
        upd_target_i = '0; upd_mispred_i = 1'b0; clr_i = 1'b0;
        #2;
        lookup(32'h40, 1'b0, 32'h44, "in_reset");
        do_reset();

        lookup(32'h40, 1'b0, 32'h44, "reset_lookup");
        check("reset_cnt", {16'd0, mispred_cnt_o}, 32'd0);

        // No bypass: update in flight, lookup of the same PC still misses.
        upd_valid_i = 1'b1; upd_pc_i = 32'h40; upd_taken_i = 1'b1;
        upd_target_i = 32'h100; upd_mispred_i = 1'b1;
        lookup(32'h40, 1'b0, 32'h44, "no_bypass");
        @(posedge clk); #1; upd_valid_i = 1'b0;
        lookup(32'h40, 1'b1, 32'h100, "alloc_hit");
        lookup(32'h80, 1'b0, 32'h84, "alias_miss");
        check("cnt_one", {16'd0, mispred_cnt_o}, 32'd1);

        update(32'h40, 1'b1, 32'h200, 1'b0);
        lookup(32'h40, 1'b1, 32'h200, "tgt_overwrite");
        update(32'hC0, 1'b0, 32'h0, 1'b0);
        lookup(32'h40, 1'b1, 32'h200, "nt_miss_noalloc");
        lookup(32'hC0, 1'b0, 32'hC4, "nt_miss_lookup");

        upd_pc_i = 32'h48; upd_taken_i = 1'b1; upd_target_i = 32'h500; upd_mispred_i = 1'b1;
        @(posedge clk); #1;
        lookup(32'h48, 1'b0, 32'h4C, "invalid_upd");
        check("invalid_cnt", {16'd0, mispred_cnt_o}, 32'd1);

        do_reset();
        for (int i = 0; i < 6; i++) begin
            update(32'h40, (i < 4), 32'h100, 1'b0);
            lookup(32'h40, exp_t[i], exp_t[i] ? 32'h100 : 32'h44, $sformatf("ctr_seq%0d", i));
        end

        update(32'h40, 1'b1, 32'h100, 1'b0);
        clr_i = 1'b1;
        update(32'h44, 1'b1, 32'h300, 1'b0);
        clr_i = 1'b0;
        lookup(32'h44, 1'b0, 32'h48, "clr_prio");
        lookup(32'h40, 1'b0, 32'h44, "clr_old");
        update(32'h40, 1'b1, 32'h140, 1'b0);
        lookup(32'h40, 1'b1, 32'h140, "realloc");

        for (int i = 0; i < 5; i++) begin
            update(32'h50, 1'b0, 32'h0, 1'b1);
            check($sformatf("cnt3_%0d", i), {16'd0, mispred_cnt3_o}, {16'd0, exp_c3[i]});
            check($sformatf("cnt_%0d", i), {16'd0, mispred_cnt_o}, 32'(i + 1));
        end
        clr_i = 1'b1;
        @(posedge clk); #1;
        clr_i = 1'b0;
        check("cnt_clr_keep", {16'd0, mispred_cnt_o}, 32'd5);

        // Reset during a pending update: counter clears at once, update is discarded.
        upd_valid_i = 1'b1; upd_pc_i = 32'h60; upd_taken_i = 1'b1;
        upd_target_i = 32'h700; upd_mispred_i = 1'b1;
        rst = 1'b0;
        #1;
        check("rst_cnt3", {16'd0, mispred_cnt3_o}, 32'd0);
        check("rst_cnt", {16'd0, mispred_cnt_o}, 32'd0);
        @(posedge clk); #1;
        upd_valid_i = 1'b0;
        rst = 1'b1;
        lookup(32'h60, 1'b0, 32'h64, "rst_discard");
        check("rst_discard_cnt", {16'd0, mispred_cnt_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have parameter ENTRIES, default 16, meaning the number of table entries (power of two, 4..256).
REQ-002 The block SHALL have parameter PC_W, default 32, meaning the PC/target width.
REQ-003 The block SHALL have parameter CNT_MAX, default 16'hFFFF, meaning the saturation value of the mispredict counter.
REQ-004 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 Port pc_i  input  PC_W  SHALL carry the IF-stage fetch PC for lookup.
REQ-007 Port pred_taken_o  output  1  SHALL be the predicted direction for pc_i.
REQ-008 Port pred_target_o  output  PC_W  SHALL be the predicted target; it equals pc_i+4 when pred_taken_o=0.
REQ-009 Port upd_valid_i  input  1  SHALL qualify an EX-stage resolved-branch update.
REQ-010 Port upd_pc_i  input  PC_W  SHALL carry the PC of the resolved branch.
REQ-011 Port upd_taken_i  input  1  SHALL carry the actual outcome.
REQ-012 Port upd_target_i  input  PC_W  SHALL carry the actual taken target.
REQ-013 Port upd_mispred_i  input  1  SHALL flag that the resolved branch was mispredicted.
REQ-014 Port clr_i  input  1  SHALL request a synchronous invalidate of all entries.
REQ-015 Port mispred_cnt_o  output  16  SHALL count mispredictions.

Function
REQ-016 Index SHALL be pc[IDX_W+1:2] and tag SHALL be pc[PC_W-1:IDX_W+2], with IDX_W=log2(ENTRIES).
REQ-017 Each entry SHALL hold valid, tag, target and a 2-bit counter (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
REQ-018 Lookup SHALL be combinational from registered state: hit = valid && tag match; pred_taken_o = hit && ctr[1].
REQ-019 An update whose tag hits SHALL increment ctr on taken and decrement on not-taken, saturating at 11 and 00.
REQ-020 An update that hits with taken=1 SHALL overwrite the entry target with upd_target_i.
REQ-021 An update that misses with taken=1 SHALL allocate: valid=1, new tag, target=upd_target_i, ctr=10.
REQ-022 An update that misses with taken=0 SHALL leave the table unchanged.
REQ-023 Update latency SHALL be one cycle; a same-cycle lookup of the updated index SHALL see the pre-update state (no bypass).
REQ-024 clr_i SHALL clear all valid bits next edge; counters and targets are unchanged; clr_i SHALL take priority over a simultaneous update.
REQ-025 mispred_cnt_o SHALL increment by 1 per cycle with upd_valid_i && upd_mispred_i and hold at CNT_MAX; clr_i SHALL NOT reset it.
REQ-026 Inputs upd_* other than upd_valid_i SHALL be ignored when upd_valid_i=0.

Reset
REQ-027 rst low SHALL immediately clear all valid bits, set all counters to 01, targets/tags to 0, and mispred_cnt_o to 0.
REQ-028 During reset pred_taken_o SHALL be 0 and pred_target_o SHALL be pc_i+4; reset mid-update SHALL discard that update.

Structure
REQ-029 Counter encodings, the CNT_MAX default and the allocation counter value (10) SHALL live in the shared package bp_pkg.
REQ-030 The 2-bit saturating counter SHALL be the one sub-module, bp_sat_ctr (inputs inc/dec/en, output state).
REQ-031 The table SHALL be flip-flop arrays (no RAM macro), ENTRIES deep.

Verification
REQ-032 Reset, then pc_i=0x0000_0040 -> pred_taken_o=0, pred_target_o=0x0000_0044, mispred_cnt_o=0.
REQ-033 Update pc=0x40 taken target=0x100, then lookup 0x40 -> taken=1, target=0x100; lookup 0x80 (same index, ENTRIES=16, different tag) -> taken=0.
REQ-034 Four taken updates then two not-taken on pc=0x40 -> ctr 10,11,11,11,10,01; final lookup taken=0.
REQ-035 clr_i and a taken update to pc=0x44 in the same cycle -> next cycle lookup 0x44 taken=0; a prior entry 0x40 is also invalid.
REQ-036 With CNT_MAX=3, five mispredict updates -> mispred_cnt_o=1,2,3,3,3; assert rst low mid-stream -> 0 immediately.
